round_sequencer: RTL and testbench

Game-round controller for the cat/dog/chicken two-player game. It captures both players' one-hot choices on a Choose press and resolves the round. It then asks the screen-drawing datapath to render the matching result screen over a req/done handshake and keeps the scores. It also detects a match win, draws the win screen and waits for a new game. It sits between the debounced user keys/switches and the drawing controller/datapath, and drives the score values shown on HEX0/HEX1.

---
 rtl/round_sequencer_if.sv | 9 +
 rtl/round_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_round_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/round_sequencer_if.sv
// rtl/round_sequencer_if.sv - screen draw request/done handshake between sequencer and drawing datapath
interface round_sequencer_if;
  logic       draw_req;
  logic [6:0] draw_sel;
  logic       draw_done;

  modport master (output draw_req, output draw_sel, input draw_done);
  modport slave  (input draw_req, input draw_sel, output draw_done);
endinterface

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - cat/dog/chicken round controller: key edges, scoring, screen draw requests
module round_sequencer #(
  parameter int WIN_SCORE = 3,
  parameter int SCORE_W   = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               choose,
  input  logic               cont,
  input  logic               new_game,
  input  logic [2:0]         p1_choice,
  input  logic [2:0]         p2_choice,
  round_sequencer_if.master  draw,
  output logic [SCORE_W-1:0] player1,
  output logic [SCORE_W-1:0] player2,
  output logic [1:0]         round_result,
  output logic               game_over,
  output logic               busy
);

  typedef enum logic [2:0] {
    DRAW_TITLE, WAIT_CHOOSE, DRAW_RESULT, SCORE, WAIT_CONT, DRAW_WIN, GAME_OVER
  } state_t;

  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  state_t             state, state_n;
  logic               req_q, req_n;
  logic [6:0]         sel_q, sel_n;
  logic [SCORE_W-1:0] p1_n, p2_n;
  logic [1:0]         rr_n;
  logic [1:0]         p1_idx, p2_idx, p1_idx_n, p2_idx_n;
  logic               pending, pending_n;
  logic               choose_q, cont_q, new_game_q;
  logic               choose_edge, cont_edge, new_game_edge;
  logic [1:0]         p1_now, p2_now;
  logic               p1_wins;

  // Non-one-hot codes fall back to cat.
  function automatic logic [1:0] choice_idx(input logic [2:0] c);
    case (c)
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  assign choose_edge   = choose & ~choose_q;
  assign cont_edge     = cont & ~cont_q;
  assign new_game_edge = new_game & ~new_game_q;
  assign p1_now        = choice_idx(p1_choice);
  assign p2_now        = choice_idx(p2_choice);

  // Each choice beats the one whose index is one lower, modulo 3.
  assign p1_wins = (p1_idx == 2'd1 && p2_idx == 2'd0) ||
                   (p1_idx == 2'd2 && p2_idx == 2'd1) ||
                   (p1_idx == 2'd0 && p2_idx == 2'd2);

  assign draw.draw_req  = req_q;
  assign draw.draw_sel  = sel_q;
  assign busy           = req_q;
  assign game_over      = (state == GAME_OVER);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= DRAW_TITLE;
      req_q        <= 1'b0;
      sel_q        <= 7'd0;
      player1      <= '0;
      player2      <= '0;
      round_result <= 2'b00;
      p1_idx       <= 2'd0;
      p2_idx       <= 2'd0;
      pending      <= 1'b0;
      choose_q     <= 1'b0;
      cont_q       <= 1'b0;
      new_game_q   <= 1'b0;
    end else begin
      state        <= state_n;
      req_q        <= req_n;
      sel_q        <= sel_n;
      player1      <= p1_n;
      player2      <= p2_n;
      round_result <= rr_n;
      p1_idx       <= p1_idx_n;
      p2_idx       <= p2_idx_n;
      pending      <= pending_n;
      choose_q     <= choose;
      cont_q       <= cont;
      new_game_q   <= new_game;
    end
  end

  always_comb begin
    state_n   = state;
    req_n     = req_q;
    sel_n     = sel_q;
    p1_n      = player1;
    p2_n      = player2;
    rr_n      = round_result;
    p1_idx_n  = p1_idx;
    p2_idx_n  = p2_idx;
    pending_n = pending;

    if (new_game_edge) pending_n = 1'b1;

    if (req_q) begin
      // An in-flight draw always finishes; a pending new game then replaces the normal successor.
      if (draw.draw_done) begin
        req_n = 1'b0;
        if (pending || new_game_edge) begin
          state_n = DRAW_TITLE;
        end else begin
          case (state)
            DRAW_TITLE:  state_n = WAIT_CHOOSE;
            DRAW_RESULT: state_n = SCORE;
            DRAW_WIN:    state_n = GAME_OVER;
            default:     state_n = DRAW_TITLE;
          endcase
        end
      end
    end else if (new_game_edge) begin
      state_n = state;
    end else if (pending) begin
      p1_n      = '0;
      p2_n      = '0;
      rr_n      = 2'b00;
      pending_n = 1'b0;
      state_n   = DRAW_TITLE;
      sel_n     = 7'd0;
      req_n     = 1'b1;
    end else begin
      case (state)
        DRAW_TITLE: begin
          sel_n = 7'd0;
          req_n = 1'b1;
        end
        WAIT_CHOOSE: begin
          if (choose_edge) begin
            p1_idx_n = p1_now;
            p2_idx_n = p2_now;
            sel_n    = 7'd1 + 7'd3 * {5'd0, p2_now} + {5'd0, p1_now};
            req_n    = 1'b1;
            state_n  = DRAW_RESULT;
          end
        end
        DRAW_RESULT, DRAW_WIN: req_n = 1'b1;
        SCORE: begin
          if (p1_idx == p2_idx) begin
            rr_n = 2'b00;
          end else if (p1_wins) begin
            rr_n = 2'b01;
            if (player1 < WIN) p1_n = player1 + SCORE_ONE;
          end else begin
            rr_n = 2'b10;
            if (player2 < WIN) p2_n = player2 + SCORE_ONE;
          end
          state_n = WAIT_CONT;
        end
        WAIT_CONT: begin
          if (cont_edge) begin
            req_n = 1'b1;
            if (player1 == WIN) begin
              sel_n   = 7'd10;
              state_n = DRAW_WIN;
            end else if (player2 == WIN) begin
              sel_n   = 7'd11;
              state_n = DRAW_WIN;
            end else begin
              sel_n   = 7'd0;
              state_n = DRAW_TITLE;
            end
          end
        end
        default: state_n = state;
      endcase
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - self-checking bench for round_sequencer
module tb_round_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       choose = 1'b0;
  logic       cont = 1'b0;
  logic       new_game = 1'b0;
  logic [2:0] p1_choice = 3'b000;
  logic [2:0] p2_choice = 3'b000;
  logic [3:0] player1, player2;
  logic [1:0] round_result;
  logic       game_over, busy;

  round_sequencer_if dif ();

  round_sequencer #(.WIN_SCORE(3), .SCORE_W(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .choose       (choose),
    .cont         (cont),
    .new_game     (new_game),
    .p1_choice    (p1_choice),
    .p2_choice    (p2_choice),
    .draw         (dif),
    .player1      (player1),
    .player2      (player2),
    .round_result (round_result),
    .game_over    (game_over),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] p1;
    logic [2:0] p2;
    int         sel;
    int         rr;
    int         s1;
    int         s2;
    int         next_sel;
    int         delay;
  } row_t;

  row_t rows [7];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_draw(input int exp_sel, input int delay, input string tag);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (!dif.draw_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, " req"}, int'(dif.draw_req), 1);
    check({tag, " sel"}, int'(dif.draw_sel), exp_sel);
    check({tag, " busy"}, int'(busy), 1);
    repeat (delay) begin
      tick();
      if (!dif.draw_req || dif.draw_sel != 7'(exp_sel)) bad++;
    end
    check({tag, " hold"}, bad, 0);
    dif.draw_done = 1'b1;
    tick();
    dif.draw_done = 1'b0;
    check({tag, " release"}, int'(dif.draw_req), 0);
  endtask

  task automatic no_req(input int cycles, input string tag);
    int seen;
    seen = 0;
    repeat (cycles) begin
      tick();
      if (dif.draw_req) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic play_round(input row_t r, input string tag);
    p1_choice = r.p1;
    p2_choice = r.p2;
    choose = 1'b1;
    tick();
    check({tag, " latency"}, int'(dif.draw_req), 1);
    choose = 1'b0;
    do_draw(r.sel, r.delay, tag);
    tick();
    check({tag, " p1"}, int'(player1), r.s1);
    check({tag, " p2"}, int'(player2), r.s2);
    check({tag, " rr"}, int'(round_result), r.rr);
  endtask

  task automatic press_cont(input int next_sel, input string tag);
    cont = 1'b1;
    tick();
    cont = 1'b0;
    do_draw(next_sel, 1, tag);
  endtask

  initial begin
    rows[0] = '{3'b010, 3'b001, 2, 1, 1, 0, 0, 50};
    rows[1] = '{3'b100, 3'b100, 9, 0, 1, 0, 0, 2};
    rows[2] = '{3'b011, 3'b100, 7, 1, 2, 0, 0, 2};
    rows[3] = '{3'b001, 3'b010, 4, 2, 2, 1, 0, 2};
    rows[4] = '{3'b001, 3'b010, 4, 2, 0, 1, 0, 3};
    rows[5] = '{3'b001, 3'b010, 4, 2, 0, 2, 0, 0};
    rows[6] = '{3'b001, 3'b010, 4, 2, 0, 3, 11, 1};
    dif.draw_done = 1'b0;

    repeat (3) tick();
    check("rst req", int'(dif.draw_req), 0);
    check("rst sel", int'(dif.draw_sel), 0);
    check("rst scores", int'({player1, player2}), 0);
    check("rst rr", int'(round_result), 0);
    check("rst game_over", int'(game_over), 0);
    check("rst busy", int'(busy), 0);
    resetn = 1'b1;
    tick();
    check("first req", int'(dif.draw_req), 1);
    do_draw(0, 0, "title0");

    for (int i = 0; i < 4; i++) begin
      play_round(rows[i], $sformatf("row%0d", i));
      press_cont(rows[i].next_sel, $sformatf("row%0d cont", i));
    end

    // New game arrives while a result screen is still being drawn.
    p1_choice = 3'b001;
    p2_choice = 3'b010;
    choose = 1'b1;
    tick();
    choose = 1'b0;
    check("ng req", int'(dif.draw_req), 1);
    repeat (5) tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    do_draw(4, 14, "ng draw");
    check("ng rr kept", int'(round_result), 2);
    tick();
    check("ng title req", int'(dif.draw_req), 1);
    check("ng title sel", int'(dif.draw_sel), 0);
    check("ng scores", int'({player1, player2}), 0);
    check("ng rr", int'(round_result), 0);
    do_draw(0, 0, "ng title");

    for (int i = 4; i < 7; i++) begin
      play_round(rows[i], $sformatf("row%0d", i));
      press_cont(rows[i].next_sel, $sformatf("row%0d cont", i));
    end
    check("game_over", int'(game_over), 1);
    choose = 1'b1;
    tick();
    choose = 1'b0;
    tick();
    cont = 1'b1;
    tick();
    cont = 1'b0;
    no_req(8, "gameover idle");
    check("gameover p1", int'(player1), 0);
    check("gameover p2", int'(player2), 3);
    check("gameover held", int'(game_over), 1);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    tick();
    check("restart req", int'(dif.draw_req), 1);
    check("restart scores", int'({player1, player2}), 0);
    check("restart game_over", int'(game_over), 0);
    do_draw(0, 0, "restart title");

    // Choose only acts as an edge in WAIT_CHOOSE.
    rows[0].delay = 1;
    play_round(rows[0], "edge round");
    choose = 1'b1;
    no_req(5, "choose in wait_cont");
    press_cont(0, "edge cont");
    no_req(5, "choose held");
    choose = 1'b0;
    tick();
    play_round(rows[1], "edge tie");

    cont = 1'b1;
    tick();
    cont = 1'b0;
    check("midreset req before", int'(dif.draw_req), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("midreset req drop", int'(dif.draw_req), 0);
    check("midreset scores", int'({player1, player2}), 0);
    tick();
    resetn = 1'b1;
    tick();
    check("midreset restart", int'(dif.draw_req), 1);
    do_draw(0, 0, "midreset title");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
